capsense_scan_ctrl: RTL and testbench
=====================================

Name: capsense_scan_ctrl

Overview:
- Scan controller for the RC-discharge capacitive buttons.
- Sequences each scan: drives the shared pad OE to discharge the pads, then releases them and times each pad's charge in sample ticks.
- Tracks a per-button baseline and debounces the pressed/released decision.
- Sits between the SB_IO tristate pads and user logic; replaces free-running counter-compare sensing.

Parameters:
- N, 6, number of buttons.
- CW, 8, charge-count width; a count saturates at 2^CW-1 (timeout).
- SAMP_DIV, 16, clk cycles per sample tick; must be ≥ 2.
- DIS_TICKS, 24, sample ticks OE stays high for discharge.
- THRESH, 6, count margin above baseline that means "touched".
- DEB, 3, consecutive identical raw results needed to change a debounced bit; must be ≥ 1.

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous reset, active high.
- start_i  in  1  scan request pulse; sampled only in IDLE.
- pads_i  in  N  pad inputs from SB_IO D_IN_0 (asynchronous).
- pads_oe_o  out  1  pad output enable; the pad data-out is tied to 0.
- busy_o  out  1  high while a scan is in progress.
- done_o  out  1  one-cycle pulse when a scan completes.
- buttons_o  out  N  debounced pressed state.
- raw_o  out  N  undebounced result of the last scan.
- cal_o  out  1  high once the baseline has been captured.

Behaviour:
- Reset: state=IDLE; pads_oe_o=1 (pads held discharged); busy_o=0; done_o=0; buttons_o=0; raw_o=0; cal_o=0; all counts, baselines and debounce counters = 0; divider = 0.
- Sync: pads_i passes through a 2-FF synchronizer. The 2-cycle latency is common to all pads and is not compensated.
- Tick: the divider wraps at SAMP_DIV-1. tick=1 when the divider = 0. The divider runs only when state is not IDLE and is cleared on entry to DISCHARGE.

FSM:
- IDLE: pads_oe_o=1, busy_o=0. If start_i, go to DISCHARGE and clear all counts.
- DISCHARGE: pads_oe_o=1. Count DIS_TICKS ticks, then go to CHARGE.
- CHARGE: pads_oe_o=0.
  - On each tick, every pad whose synchronized input is still 0 increments its count. Increments saturate at 2^CW-1.
  - A pad reading 1 freezes its count.
  - When all pads read 1 on a tick, or the tick counter reaches 2^CW-1 (timeout), go to EVAL.
  - Uncharged pads keep the saturated count.
- EVAL: pads_oe_o=1, exactly N cycles, one button per cycle (index k = 0..N-1), using a single shared comparator:
  - If cal_o=0: baseline[k]=count[k]; raw[k]=0.
  - Else: raw[k] = (count[k] > baseline[k]+THRESH), computed at CW+1 bits with no wrap.
  - If raw[k]=0 and count[k]≠baseline[k]: baseline[k] moves by ±1 toward count[k]. A touched button freezes its baseline.
  - Debounce per button: if raw[k]≠buttons_o[k], deb[k] increments, and when it reaches DEB, buttons_o[k] toggles and deb[k] clears. If raw[k]=buttons_o[k], deb[k] clears.
- DONE: one cycle. done_o=1; raw_o is updated; cal_o is set to 1. Return to IDLE.

Boundaries:
- start_i outside IDLE is ignored; it is not queued.
- start_i asserted continuously gives back-to-back scans separated by one IDLE cycle.
- A pad stuck at 0 reaches saturation, is treated as touched once calibrated, and never updates its baseline.
- A pad stuck at 1 gives count 0 and is never touched.
- rst_i mid-scan: the next cycle is the reset state. OE returns high immediately and calibration is lost.
- Scan latency from start_i to done_o = 1 + DIS_TICKS·SAMP_DIV + charge time + N + 1 cycles.

Decomposition:
- Package capsense_pkg: state encoding localparams (IDLE, DISCHARGE, CHARGE, EVAL, DONE), a CW-bit saturating-max constant, and a width helper for the DEB counter.
- Sub-module capsense_tick_div: the SAMP_DIV prescaler with clear input and tick output.
- The per-button compare/baseline/debounce logic stays in the top as the shared EVAL datapath.

Test Plan:
- Reset then idle → pads_oe_o=1, buttons_o=0, cal_o=0, busy_o=0; no done_o pulse with start_i low for 1000 cycles.
- First scan, N=6, all pads rise after 10 ticks → done_o once; cal_o=1; raw_o=0; baseline=10 each; pads_oe_o low only during CHARGE (exactly 24·16 high cycles before it).
- Calibrated, pad 2 rises at tick 20 and others at 10 (20 > 10+6) → raw_o=6'b000100; buttons_o[2] rises after the 3rd such scan, not before; baseline[2] stays 10.
- Pad 2 back to 10 ticks → buttons_o[2] falls after 3 scans. Separately, alternating touched/untouched scans → buttons_o stays 0.
- Pad 0 held low → CHARGE ends at count 255 timeout; raw_o[0]=1 after calibration; other pads unaffected.
- rst_i asserted mid-CHARGE → next cycle pads_oe_o=1, busy_o=0, cal_o=0; start_i during busy ignored (exactly one done_o per accepted start).

Source files
------------

// File: rtl/capsense_pkg.sv
// Shared types and constants for the capacitive-button scan controller.
package capsense_pkg;

    // Scan sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DISCHARGE = 3'd1,
        ST_CHARGE    = 3'd2,
        ST_EVAL      = 3'd3,
        ST_DONE      = 3'd4
    } state_e;

    // Default charge-count width and its saturation value (timeout count).
    localparam int unsigned CAP_CW      = 8;
    localparam int unsigned CAP_CNT_MAX = (1 << CAP_CW) - 1;

    // Number of bits needed to hold values 0..max_val (at least 1).
    function automatic int unsigned cnt_w(input int unsigned max_val);
        int unsigned w;
        w = 1;
        for (int i = 1; i < 32; i++) begin
            if ((max_val >> i) != 0) w = i + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/capsense_tick_div.sv
// Sample-tick prescaler: counts 0..SAMP_DIV-1, tick when the count is zero.
module capsense_tick_div
    import capsense_pkg::*;
#(
    parameter int unsigned SAMP_DIV = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic run_i,
    input  logic clr_i,
    output logic tick_c,
    output logic wrap_c
);

    localparam int unsigned     DW   = cnt_w(SAMP_DIV - 1);
    localparam logic [DW-1:0]   LAST = DW'(SAMP_DIV - 1);

    logic [DW-1:0] div_q, div_d;

    // Next divider value: clear wins, otherwise wrap-count while running.
    always_comb begin
        div_d = div_q;
        if (clr_i) begin
            div_d = '0;
        end else if (run_i) begin
            div_d = (div_q == LAST) ? '0 : div_q + DW'(1);
        end
    end

    // Divider register.
    always_ff @(posedge clk_i) begin
        if (rst_i) div_q <= '0;
        else       div_q <= div_d;
    end

    assign tick_c = (div_q == '0);
    assign wrap_c = (div_q == LAST);

endmodule

// File: rtl/capsense_scan_ctrl.sv
// RC-discharge capacitive button scanner: discharge, time charge, evaluate, debounce.
module capsense_scan_ctrl
    import capsense_pkg::*;
#(
    parameter int unsigned N         = 6,
    parameter int unsigned CW        = CAP_CW,
    parameter int unsigned SAMP_DIV  = 16,
    parameter int unsigned DIS_TICKS = 24,
    parameter int unsigned THRESH    = 6,
    parameter int unsigned DEB       = 3
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         start_i,
    input  logic [N-1:0] pads_i,
    output logic         pads_oe_o,
    output logic         busy_o,
    output logic         done_o,
    output logic [N-1:0] buttons_o,
    output logic [N-1:0] raw_o,
    output logic         cal_o
);

    localparam int unsigned    DBW      = cnt_w(DEB);
    localparam int unsigned    DCW      = cnt_w(DIS_TICKS);
    localparam int unsigned    KW       = cnt_w(N - 1);
    localparam logic [CW-1:0]  CNT_MAX  = '1;
    localparam logic [CW-1:0]  CNT_LAST = CNT_MAX - CW'(1);
    localparam logic [CW:0]    THR      = (CW + 1)'(THRESH);

    state_e                 state_q, state_d;
    logic [N-1:0]           sync1_q, sync1_d, sync2_q, sync2_d;
    logic [N-1:0][CW-1:0]   cnt_q, cnt_d, base_q, base_d;
    logic [N-1:0][DBW-1:0]  deb_q, deb_d;
    logic [N-1:0]           btn_q, btn_d, raw_work_q, raw_work_d, raw_q, raw_d;
    logic                   cal_q, cal_d, oe_q, oe_d, busy_q, busy_d, done_q, done_d;
    logic [DCW-1:0]         dis_cnt_q, dis_cnt_d;
    logic [CW-1:0]          tcnt_q, tcnt_d;
    logic [KW-1:0]          k_q, k_d;

    logic                   tick_c, wrap_c, div_run_c, div_clr_c;
    logic [CW-1:0]          cnt_k_c, base_k_c, base_new_c;
    logic [DBW-1:0]         deb_k_c, deb_new_c;
    logic                   btn_k_c, btn_new_c, raw_k_c;
    logic [CW:0]            limit_c;

    assign div_run_c = (state_q != ST_IDLE);
    assign div_clr_c = (state_q == ST_IDLE) && start_i;

    capsense_tick_div #(
        .SAMP_DIV (SAMP_DIV)
    ) u_tick_div (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .run_i  (div_run_c),
        .clr_i  (div_clr_c),
        .tick_c (tick_c),
        .wrap_c (wrap_c)
    );

    // Shared EVAL datapath: select button k, compare, move baseline, debounce.
    always_comb begin
        cnt_k_c  = '0;
        base_k_c = '0;
        deb_k_c  = '0;
        btn_k_c  = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (k_q == KW'(k)) begin
                cnt_k_c  = cnt_q[k];
                base_k_c = base_q[k];
                deb_k_c  = deb_q[k];
                btn_k_c  = btn_q[k];
            end
        end
        limit_c = {1'b0, base_k_c} + THR;
        raw_k_c = cal_q && ({1'b0, cnt_k_c} > limit_c);

        base_new_c = base_k_c;
        if (!cal_q) begin
            base_new_c = cnt_k_c;
        end else if (!raw_k_c && (cnt_k_c > base_k_c)) begin
            base_new_c = base_k_c + CW'(1);
        end else if (!raw_k_c && (cnt_k_c < base_k_c)) begin
            base_new_c = base_k_c - CW'(1);
        end

        btn_new_c = btn_k_c;
        deb_new_c = '0;
        if (raw_k_c != btn_k_c) begin
            if (deb_k_c == DBW'(DEB - 1)) btn_new_c = ~btn_k_c;
            else                          deb_new_c = deb_k_c + DBW'(1);
        end
    end

    // Scan sequencer next-state and datapath updates; outputs follow the next state.
    always_comb begin
        state_d    = state_q;
        sync1_d    = pads_i;
        sync2_d    = sync1_q;
        cnt_d      = cnt_q;
        base_d     = base_q;
        deb_d      = deb_q;
        btn_d      = btn_q;
        raw_work_d = raw_work_q;
        raw_d      = raw_q;
        cal_d      = cal_q;
        dis_cnt_d  = dis_cnt_q;
        tcnt_d     = tcnt_q;
        k_d        = k_q;

        unique case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d   = ST_DISCHARGE;
                    cnt_d     = '0;
                    tcnt_d    = '0;
                    dis_cnt_d = '0;
                    k_d       = '0;
                end
            end
            ST_DISCHARGE: begin
                if (tick_c) dis_cnt_d = dis_cnt_q + DCW'(1);
                // Leave on the last divider phase so discharge spans whole tick periods.
                if (wrap_c && (dis_cnt_q == DCW'(DIS_TICKS))) state_d = ST_CHARGE;
            end
            ST_CHARGE: begin
                if (tick_c) begin
                    for (int k = 0; k < N; k++) begin
                        if (!sync2_q[k] && (cnt_q[k] != CNT_MAX)) cnt_d[k] = cnt_q[k] + CW'(1);
                    end
                    tcnt_d = tcnt_q + CW'(1);
                    if ((&sync2_q) || (tcnt_q == CNT_LAST)) state_d = ST_EVAL;
                end
            end
            ST_EVAL: begin
                for (int k = 0; k < N; k++) begin
                    if (k_q == KW'(k)) begin
                        base_d[k]     = base_new_c;
                        deb_d[k]      = deb_new_c;
                        btn_d[k]      = btn_new_c;
                        raw_work_d[k] = raw_k_c;
                    end
                end
                if (k_q == KW'(N - 1)) begin
                    k_d     = '0;
                    raw_d   = raw_work_d;
                    cal_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        oe_d   = (state_d != ST_CHARGE);
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // All state and registered outputs; pads stay discharged while in reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            sync1_q    <= '0;
            sync2_q    <= '0;
            cnt_q      <= '0;
            base_q     <= '0;
            deb_q      <= '0;
            btn_q      <= '0;
            raw_work_q <= '0;
            raw_q      <= '0;
            cal_q      <= 1'b0;
            oe_q       <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dis_cnt_q  <= '0;
            tcnt_q     <= '0;
            k_q        <= '0;
        end else begin
            state_q    <= state_d;
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            cnt_q      <= cnt_d;
            base_q     <= base_d;
            deb_q      <= deb_d;
            btn_q      <= btn_d;
            raw_work_q <= raw_work_d;
            raw_q      <= raw_d;
            cal_q      <= cal_d;
            oe_q       <= oe_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            dis_cnt_q  <= dis_cnt_d;
            tcnt_q     <= tcnt_d;
            k_q        <= k_d;
        end
    end

    assign pads_oe_o = oe_q;
    assign busy_o    = busy_q;
    assign done_o    = done_q;
    assign buttons_o = btn_q;
    assign raw_o     = raw_q;
    assign cal_o     = cal_q;

endmodule

// File: tb/tb_capsense_scan_ctrl.sv
// Bench for capsense_scan_ctrl: pad RC model driver, reference model, done_o scoreboard.
module tb_capsense_scan_ctrl;

    localparam int N         = 6;
    localparam int SAMP_DIV  = 16;
    localparam int DIS_TICKS = 24;
    localparam int THRESH    = 6;
    localparam int DEB       = 3;
    localparam int CNT_MAX   = int'(capsense_pkg::CAP_CNT_MAX);
    localparam int STUCK_LOW = 999;

    logic         clk_i = 1'b0;
    logic         rst_i;
    logic         start_i;
    logic [N-1:0] pads_i;
    logic         pads_oe_o;
    logic         busy_o;
    logic         done_o;
    logic [N-1:0] buttons_o;
    logic [N-1:0] raw_o;
    logic         cal_o;

    capsense_scan_ctrl dut (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .start_i   (start_i),
        .pads_i    (pads_i),
        .pads_oe_o (pads_oe_o),
        .busy_o    (busy_o),
        .done_o    (done_o),
        .buttons_o (buttons_o),
        .raw_o     (raw_o),
        .cal_o     (cal_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [N-1:0] raw;
        logic [N-1:0] btn;
        logic         cal;
    } exp_t;

    exp_t exp_q[$];
    int   total    = 0;
    int   bad      = 0;
    int   done_cnt = 0;
    int   rise[N];          // tick index at which each pad first reads 1 (STUCK_LOW = never)
    int   m_base[N];
    int   m_deb[N];
    int   m_btn[N];
    int   m_cal;
    logic spam = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < N; k++) begin
            m_base[k] = 0;
            m_deb[k]  = 0;
            m_btn[k]  = 0;
        end
        m_cal = 0;
    endtask

    // One scan of the reference model using the current rise[] profile.
    task automatic model_scan(output exp_t e);
        int cnt;
        int raw;
        for (int k = 0; k < N; k++) begin
            cnt = (rise[k] > CNT_MAX) ? CNT_MAX : rise[k];
            raw = 0;
            if (m_cal == 0) begin
                m_base[k] = cnt;
            end else begin
                raw = (cnt > m_base[k] + THRESH) ? 1 : 0;
                if (raw == 0 && cnt > m_base[k]) m_base[k] = m_base[k] + 1;
                else if (raw == 0 && cnt < m_base[k]) m_base[k] = m_base[k] - 1;
            end
            if (raw != m_btn[k]) begin
                m_deb[k] = m_deb[k] + 1;
                if (m_deb[k] == DEB) begin
                    m_btn[k] = 1 - m_btn[k];
                    m_deb[k] = 0;
                end
            end else begin
                m_deb[k] = 0;
            end
            e.raw[k] = (raw != 0);
            e.btn[k] = (m_btn[k] != 0);
        end
        m_cal = 1;
        e.cal = 1'b1;
    endtask

    task automatic set_rise(input int all_val, input int idx, input int val);
        for (int k = 0; k < N; k++) rise[k] = all_val;
        if (idx >= 0) rise[idx] = val;
    endtask

    task automatic wait_idle(input string tag);
        int got;
        got = 0;
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk_i);
            if (!busy_o) begin
                got = 1;
                break;
            end
        end
        check({tag, "_idle_reached"}, got, 1);
    endtask

    // Full scan: request, time the phases, emulate pad charging, push the expectation.
    task automatic do_scan(input string tag);
        exp_t e;
        int   n, lo, tail, maxr, rend, got;
        for (int k = 0; k < N; k++) pads_i[k] = (rise[k] == 0);
        wait_idle(tag);
        model_scan(e);
        exp_q.push_back(e);
        start_i = 1'b1;

        n   = 0;
        got = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk_i);
            start_i = spam ? 1'($urandom_range(1, 0)) : 1'b0;
            if (!pads_oe_o) begin
                got = 1;
                break;
            end
            if (busy_o) n++;
        end
        check({tag, "_charge_seen"}, got, 1);
        check({tag, "_discharge_cycles"}, n, DIS_TICKS * SAMP_DIV);

        lo  = 1;
        got = 0;
        for (int i = 1; i < 6000; i++) begin
            @(negedge clk_i);
            if (pads_oe_o) begin
                got = 1;
                break;
            end
            lo++;
            start_i = spam ? 1'($urandom_range(1, 0)) : 1'b0;
            for (int k = 0; k < N; k++) begin
                if (rise[k] >= 1 && rise[k] < CNT_MAX && SAMP_DIV * rise[k] - 8 == i) pads_i[k] = 1'b1;
            end
        end
        start_i = 1'b0;
        maxr = 0;
        for (int k = 0; k < N; k++) if (rise[k] > maxr) maxr = rise[k];
        rend = (maxr >= CNT_MAX) ? CNT_MAX - 1 : maxr;
        check({tag, "_charge_end_seen"}, got, 1);
        check({tag, "_charge_cycles"}, lo, SAMP_DIV * rend + 1);

        tail = 0;
        got  = 0;
        for (int i = 0; i < 100; i++) begin
            if (!busy_o) begin
                got = 1;
                break;
            end
            tail++;
            @(negedge clk_i);
        end
        check({tag, "_eval_done_cycles"}, tail, N + 1);
        pads_i = '0;
    endtask

    // Scoreboard monitor: every done_o pulse consumes one expectation.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk_i);
            if (done_o === 1'b1) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    check("done_unexpected", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("raw_o", int'(raw_o), int'(e.raw));
                    check("buttons_o", int'(buttons_o), int'(e.btn));
                    check("cal_o", int'(cal_o), int'(e.cal));
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int d0, gap, got;
        exp_t e;
        rst_i   = 1'b1;
        start_i = 1'b0;
        pads_i  = '0;
        model_reset();
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("rst_oe", int'(pads_oe_o), 1);
        check("rst_busy", int'(busy_o), 0);
        check("rst_done", int'(done_o), 0);
        check("rst_buttons", int'(buttons_o), 0);
        check("rst_raw", int'(raw_o), 0);
        check("rst_cal", int'(cal_o), 0);

        d0 = done_cnt;
        repeat (1000) @(negedge clk_i);
        check("idle_no_done", done_cnt - d0, 0);
        check("idle_oe", int'(pads_oe_o), 1);

        // Calibration scan, then touch/release/alternate on pad 2.
        set_rise(10, -1, 0);
        do_scan("cal");
        for (int s = 0; s < 3; s++) begin
            set_rise(10, 2, 20);
            do_scan("touch2");
        end
        for (int s = 0; s < 3; s++) begin
            set_rise(10, 2, 10);
            do_scan("release2");
        end
        for (int s = 0; s < 4; s++) begin
            set_rise(10, 2, (s % 2 == 0) ? 20 : 10);
            do_scan("alt2");
        end
        set_rise(10, 2, 17);
        do_scan("thr_above");
        set_rise(10, 2, 16);
        do_scan("thr_equal");

        // Pad 0 never charges: timeout at saturation.
        set_rise(10, 0, STUCK_LOW);
        do_scan("stuck0");

        // start_i chatter during a scan must not queue extra scans.
        d0   = done_cnt;
        spam = 1'b1;
        set_rise(11, -1, 0);
        do_scan("spam");
        spam = 1'b0;
        repeat (3) @(negedge clk_i);
        check("spam_single_done", done_cnt - d0, 1);

        // Continuous start: back-to-back scans with one idle cycle between.
        set_rise(0, -1, 0);
        pads_i = '1;
        wait_idle("b2b");
        model_scan(e);
        exp_q.push_back(e);
        model_scan(e);
        exp_q.push_back(e);
        d0      = done_cnt;
        start_i = 1'b1;
        got     = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_i);
            if (done_o) begin
                got = 1;
                break;
            end
        end
        check("b2b_first_done", got, 1);
        gap = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (busy_o) break;
            gap++;
        end
        start_i = 1'b0;
        check("b2b_gap", gap, 1);
        wait_idle("b2b_end");
        repeat (3) @(negedge clk_i);
        check("b2b_dones", done_cnt - d0, 2);
        pads_i = '0;

        // Reset in the middle of CHARGE drops calibration and returns OE high at once.
        set_rise(STUCK_LOW, -1, 0);
        wait_idle("rst_mid");
        d0      = done_cnt;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        got     = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk_i);
            if (!pads_oe_o) begin
                got = 1;
                break;
            end
        end
        check("rst_mid_charge_seen", got, 1);
        repeat (40) @(negedge clk_i);
        rst_i = 1'b1;
        @(negedge clk_i);
        check("rst_mid_oe", int'(pads_oe_o), 1);
        check("rst_mid_busy", int'(busy_o), 0);
        check("rst_mid_cal", int'(cal_o), 0);
        check("rst_mid_buttons", int'(buttons_o), 0);
        rst_i = 1'b0;
        model_reset();
        repeat (300) @(negedge clk_i);
        check("rst_mid_no_done", done_cnt - d0, 0);
        set_rise(10, -1, 0);
        do_scan("recal");

        // Randomised pad profiles.
        for (int s = 0; s < 20; s++) begin
            for (int k = 0; k < N; k++) begin
                int p;
                p = int'($urandom_range(99, 0));
                if (p < 70)      rise[k] = int'($urandom_range(13, 8));
                else if (p < 90) rise[k] = int'($urandom_range(30, 18));
                else if (p < 98) rise[k] = 0;
                else             rise[k] = STUCK_LOW;
            end
            do_scan("rnd");
        end

        repeat (5) @(negedge clk_i);
        check("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
